// File: rtl/adder_tree_accum.sv
// adder_tree_accum: registered binary adder tree feeding a pass/accumulate output stage
module adder_tree_accum #(
  parameter int N_IN  = 3,
  parameter int IN_W  = 16,
  parameter int OUT_W = 18,
  parameter bit SAT   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    mode,
  input  logic                    in_valid,
  input  logic [N_IN*IN_W-1:0]    in_data,
  input  logic                    in_first,
  input  logic                    in_last,
  output logic                    out_valid,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_sat
);
  localparam int L = $clog2(N_IN);
  localparam logic signed [OUT_W-1:0] MAX_V = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] MIN_V = {1'b1, {(OUT_W-1){1'b0}}};
  typedef struct packed {
    logic v;
    logic f;
    logic l;
    logic m;
  } ctrl_t;
  logic signed [OUT_W-1:0] node   [L+1][N_IN];
  logic signed [OUT_W-1:0] tree_d [L][N_IN];
  logic signed [OUT_W-1:0] tree_q [L][N_IN];
  ctrl_t ctrl_q [L];
  ctrl_t c;
  logic signed [OUT_W-1:0] sum, add, res;
  logic signed [OUT_W-1:0] acc_q, acc_d, out_data_q, out_data_d;
  logic gsat_q, gsat_d, out_valid_q, out_valid_d, out_sat_q, out_sat_d;
  logic ovf, take;
  for (genvar k = 0; k < N_IN; k++) begin : g_ext
    assign node[0][k] = {{(OUT_W-IN_W){in_data[k*IN_W+IN_W-1]}}, in_data[k*IN_W +: IN_W]};
  end
  // Level s holds ceil(N_IN / 2^s) live operands; an odd leftover passes through unchanged.
  for (genvar s = 0; s < L; s++) begin : g_lvl
    localparam int NS = (N_IN + (1 << s) - 1) >> s;
    for (genvar j = 0; j < N_IN; j++) begin : g_node
      if (2*j+1 < NS) begin : g_add
        assign tree_d[s][j] = node[s][2*j] + node[s][2*j+1];
      end else if (2*j < NS) begin : g_pass
        assign tree_d[s][j] = node[s][2*j];
      end else begin : g_zero
        assign tree_d[s][j] = '0;
      end
      assign node[s+1][j] = tree_q[s][j];
    end
  end
  // A first beat loads the sum directly, so only continuing beats can overflow.
  always_comb begin
    c           = ctrl_q[L-1];
    sum         = node[L][0];
    add         = (c.f ? '0 : acc_q) + sum;
    ovf         = SAT && !c.f && (acc_q[OUT_W-1] == sum[OUT_W-1]) && (add[OUT_W-1] != sum[OUT_W-1]);
    res         = ovf ? (sum[OUT_W-1] ? MIN_V : MAX_V) : add;
    take        = c.v && c.m;
    acc_d       = take ? res : acc_q;
    gsat_d      = take ? ((!c.f && gsat_q) || ovf) : gsat_q;
    out_valid_d = c.v && (!c.m || c.l);
    out_data_d  = !out_valid_d ? out_data_q : (c.m ? res : sum);
    out_sat_d   = !out_valid_d ? out_sat_q : (c.m && gsat_d);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < L; s++) begin
        ctrl_q[s] <= '0;
        for (int j = 0; j < N_IN; j++) tree_q[s][j] <= '0;
      end
      acc_q       <= '0;
      gsat_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (enable) begin
      ctrl_q[0] <= {in_valid, in_first, in_last, mode};
      for (int s = 1; s < L; s++) ctrl_q[s] <= ctrl_q[s-1];
      for (int s = 0; s < L; s++)
        for (int j = 0; j < N_IN; j++) tree_q[s][j] <= tree_d[s][j];
      acc_q       <= acc_d;
      gsat_q      <= gsat_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
endmodule

// File: tb/tb_adder_tree_accum.sv
// tb_adder_tree_accum: scoreboard bench driving a saturating and a wrapping instance with shared stimulus
module tb_adder_tree_accum;
  localparam int N = 3, W = 16, OW = 18, L = 2;
  localparam int MAXV = 131071, MINV = -131072;
  typedef struct {
    int data;
    bit sat;
    int cyc;
  } exp_t;
  logic clk = 0, rst_n = 1, enable = 0, mode = 0, in_valid = 0, in_first = 0, in_last = 0;
  logic [N*W-1:0] in_data = '0;
  logic ov1, os1, ov0, os0;
  logic signed [OW-1:0] od1, od0;
  exp_t q1[$], q0[$];
  int n_cmp = 0, n_err = 0, en_cnt = 0;
  int a1 = 0, a0 = 0, p_d1 = 0, p_d0 = 0;
  bit g1 = 0, last_en = 0, p_s1 = 0, p_s0 = 0;
  adder_tree_accum #(.N_IN(N), .IN_W(W), .OUT_W(OW), .SAT(1'b1)) u_sat (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .out_valid(ov1), .out_data(od1), .out_sat(os1));
  adder_tree_accum #(.N_IN(N), .IN_W(W), .OUT_W(OW), .SAT(1'b0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .in_valid(in_valid),
    .in_data(in_data), .in_first(in_first), .in_last(in_last),
    .out_valid(ov0), .out_data(od0), .out_sat(os0));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int wrap(input int t);
    logic [OW-1:0] x;
    x = t[OW-1:0];
    return int'($signed(x));
  endfunction
  function automatic logic [N*W-1:0] ops(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction
  function automatic logic [W-1:0] rnd_op();
    int r;
    r = $urandom_range(0, 3);
    return r == 0 ? 16'h7FFF : r == 1 ? 16'h8000 : 16'($urandom);
  endfunction
  // Reference: each accepted beat is resolved in issue order with plain integer arithmetic.
  task automatic model(input bit m, input bit f, input bit l, input logic [N*W-1:0] d);
    int s, t;
    exp_t e;
    s = 0;
    for (int k = 0; k < N; k++) s += int'($signed(d[k*W +: W]));
    e.cyc = en_cnt + 1 + L;
    if (!m) begin
      e.data = s;
      e.sat = 0;
      q1.push_back(e);
      q0.push_back(e);
    end else begin
      if (f) begin
        a1 = s;
        g1 = 0;
        a0 = s;
      end else begin
        t = a1 + s;
        if (t > MAXV) begin
          t = MAXV;
          g1 = 1;
        end else if (t < MINV) begin
          t = MINV;
          g1 = 1;
        end
        a1 = t;
        a0 = wrap(a0 + s);
      end
      if (l) begin
        e.data = a1;
        e.sat = g1;
        q1.push_back(e);
        e.data = a0;
        e.sat = 0;
        q0.push_back(e);
      end
    end
  endtask
  task automatic drive(input bit en, input bit v, input bit m, input bit f, input bit l, input logic [N*W-1:0] d);
    @(negedge clk);
    enable = en;
    in_valid = v;
    mode = m;
    in_first = f;
    in_last = l;
    in_data = d;
    if (en && v) model(m, f, l, d);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 0;
    in_valid = 0;
    enable = 1;
    #1 chk("rst_clear_sat", int'({ov1, os1, od1}), 0);
    chk("rst_clear_wrap", int'({ov0, os0, od0}), 0);
    q1.delete();
    q0.delete();
    a1 = 0;
    a0 = 0;
    g1 = 0;
    @(negedge clk);
    #2 rst_n = 1;
  endtask
  always @(posedge clk) begin
    last_en <= enable && rst_n;
    if (enable && rst_n) en_cnt <= en_cnt + 1;
  end
  // Monitor: pops on each fresh output pulse, otherwise requires the outputs to hold.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      p_d1 = 0; p_s1 = 0; p_d0 = 0; p_s0 = 0;
    end else begin
      if (ov1 && last_en) begin
        if (q1.size() == 0) chk("sat_unexpected_valid", 1, 0);
        else begin
          e = q1.pop_front();
          chk("sat_data", od1, e.data);
          chk("sat_flag", int'(os1), int'(e.sat));
          chk("sat_latency", en_cnt, e.cyc);
        end
      end else begin
        chk("sat_hold_data", od1, p_d1);
        chk("sat_hold_flag", int'(os1), int'(p_s1));
      end
      if (ov0 && last_en) begin
        if (q0.size() == 0) chk("wrap_unexpected_valid", 1, 0);
        else begin
          e = q0.pop_front();
          chk("wrap_data", od0, e.data);
          chk("wrap_flag", int'(os0), int'(e.sat));
          chk("wrap_latency", en_cnt, e.cyc);
        end
      end else begin
        chk("wrap_hold_data", od0, p_d0);
        chk("wrap_hold_flag", int'(os0), int'(p_s0));
      end
      p_d1 = od1; p_s1 = os1; p_d0 = od0; p_s0 = os0;
    end
  end
  initial begin
    #1 rst_n = 0;
    #1 chk("por_clear_sat", int'({ov1, os1, od1}), 0);
    chk("por_clear_wrap", int'({ov0, os0, od0}), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1;
    drive(1, 1, 0, 0, 0, ops(32767, 32767, 32767));
    drive(1, 1, 0, 0, 0, ops(-32768, -32768, -32768));
    drive(1, 1, 1, 1, 0, ops(32767, 32767, 32767));
    drive(1, 1, 1, 0, 1, ops(32767, 32767, 32767));
    drive(1, 1, 1, 1, 0, ops(1, 2, 3));
    drive(1, 1, 1, 0, 0, ops(-1, 0, 0));
    drive(1, 1, 1, 0, 1, ops(4, 4, 4));
    drive(1, 1, 1, 1, 1, ops(5, -7, 100));
    drive(1, 1, 1, 0, 1, ops(1, 1, 1));
    drive(1, 1, 0, 0, 0, ops(10, 20, 30));
    drive(1, 1, 1, 1, 0, ops(1, 1, 1));
    drive(1, 1, 0, 0, 0, ops(-5, -5, -5));
    drive(1, 1, 1, 0, 1, ops(2, 2, 2));
    drive(1, 0, 1, 1, 1, ops(9, 9, 9));
    for (int i = 0; i < 8; i++)
      drive(!(i == 3 || i == 4), 1, 0, 0, 0, ops(i * 1000, -i, 7));
    drive(1, 1, 1, 1, 0, ops(100, 0, 0));
    drive(1, 1, 1, 0, 0, ops(200, 0, 0));
    do_reset();
    drive(1, 1, 1, 1, 0, ops(3, 4, 5));
    drive(1, 1, 1, 0, 1, ops(6, 0, 0));
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      drive($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
            $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, {rnd_op(), rnd_op(), rnd_op()});
    end
    repeat (10) drive(1, 0, 0, 0, 0, '0);
    chk("drain_sat", q1.size(), 0);
    chk("drain_wrap", q0.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adder_tree_accum.md
ADDER_TREE_ACCUM -- requirements
Module: adder_tree_accum

Interface
REQ-001 Parameter N_IN, default 3: number of signed operands summed per beat (N_IN >= 2).
REQ-002 Parameter IN_W, default 16: width of each operand, two's complement.
REQ-003 Parameter OUT_W, default 18: result and accumulator width, two's complement (OUT_W >= IN_W + clog2(N_IN)).
REQ-004 Parameter SAT, default 1: 1 = saturating accumulation, 0 = wrap-around.
REQ-005 clk  input  1  rising-edge clock, the only clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 enable  input  1  pipeline advance; low = every register holds its value.
REQ-008 mode  input  1  0 = pass (one result per beat), 1 = accumulate across beats.
REQ-009 in_valid  input  1  beat present on in_data.
REQ-010 in_data  input  N_IN*IN_W  operand k at bits [k*IN_W +: IN_W].
REQ-011 in_first  input  1  accumulate mode: beat starts a new group.
REQ-012 in_last  input  1  accumulate mode: beat closes the group.
REQ-013 out_valid  output  1  one-cycle pulse, out_data/out_sat valid.
REQ-014 out_data  output  OUT_W  signed result.
REQ-015 out_sat  output  1  result clamped during this result's computation.

Function
REQ-016 Operands shall be sign-extended to OUT_W before any addition; the tree sum is exact (no overflow possible per REQ-003).
REQ-017 Adder tree shall be a registered binary tree of L = clog2(N_IN) stages; odd operands pass through a stage registered, unchanged.
REQ-018 in_valid, in_first, in_last and mode shall travel the pipeline alongside the data, so mode is sampled per beat.
REQ-019 Output register stage follows the tree; latency from accepted beat to out_valid is L+1 enabled cycles (3 for N_IN=3).
REQ-020 A beat is accepted only on a rising edge with enable=1 and in_valid=1; enable=0 freezes all pipeline, accumulator and output registers, including out_valid.
REQ-021 Pass mode: out_data = tree sum, out_valid = 1, out_sat = 0 for each beat; accumulator is not modified.
REQ-022 Accumulate mode, in_first=1: acc <= sum, group sat flag <= 0; in_first=0: acc <= acc + sum.
REQ-023 With SAT=1 each accumulate add shall clamp to [-2^(OUT_W-1), 2^(OUT_W-1)-1] and set the group sat flag when clamped; with SAT=0 the add wraps modulo 2^OUT_W and the flag stays 0.
REQ-024 Accumulate beat with in_last=1: out_data = updated acc, out_sat = group sat flag including this beat, out_valid = 1; beats with in_last=0 produce out_valid = 0.
REQ-025 in_first=in_last=1 on one beat: single-beat group, result equals the tree sum.
REQ-026 Accumulate beat with in_first=0 and no open group (after reset or after a last) adds onto the current acc value (0 after reset); no error is flagged.
REQ-027 Invalid pipeline slots (valid=0) shall not update the accumulator and shall produce out_valid = 0.
REQ-028 out_data and out_sat hold their last values while out_valid = 0.

Reset
REQ-029 rst_n low shall immediately clear all pipeline data/valid registers, acc, group sat flag, out_valid, out_data and out_sat to 0, regardless of clk or enable.
REQ-030 Beats in flight at reset are discarded; first beat after rst_n rises behaves as after power-up.

Verification
REQ-031 Pass, N_IN=3: operands 0x7FFF,0x7FFF,0x7FFF -> out_data = 98301, out_valid 3 cycles later, out_sat=0; operands 0x8000 x3 -> -98304.
REQ-032 Accumulate, SAT=1: beat1 {0x7FFF x3, first}, beat2 {0x7FFF x3, last} -> single out_valid, out_data = 131071, out_sat = 1; same with SAT=0 -> out_data = 196602 - 262144 = -65542, out_sat = 0.
REQ-033 Accumulate group {1,2,3} first, {-1,0,0}, {4,4,4} last -> out_data = 17, out_valid only on the third beat's result cycle.
REQ-034 Back-to-back beats with enable dropped for 2 cycles mid-stream -> outputs identical in value and order to the uninterrupted run, delayed by exactly 2 cycles.
REQ-035 rst_n asserted between first and last beat of a group -> outputs cleared asynchronously, no out_valid for that group; a following first/last group yields its exact sum.
REQ-036 Alternate mode per beat (pass, accumulate first, pass, accumulate last) -> pass beats output their own sums, accumulator result equals sum of the two accumulate beats only.
